// File: rtl/load_response_align.sv
// load_response_align: in-order load tracking FIFO that matches sub-unit responses to issued loads
// and emits a registered, aligned, sign/zero-extended writeback tagged with the load id.
module load_response_align #(
    parameter int NUM_SUB_UNITS = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int ID_W = 3,
    localparam int SW = (NUM_SUB_UNITS > 1) ? $clog2(NUM_SUB_UNITS) : 1,
    localparam int AW = $clog2(MAX_INFLIGHT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [SW-1:0]               issue_sub_id,
    input  logic [2:0]                  issue_fn3,
    input  logic [1:0]                  issue_offset,
    input  logic [ID_W-1:0]             issue_id,
    input  logic [NUM_SUB_UNITS-1:0]    sub_data_valid,
    input  logic [32*NUM_SUB_UNITS-1:0] sub_data_out,
    output logic                        wb_valid,
    output logic [ID_W-1:0]             wb_id,
    output logic [31:0]                 wb_data,
    output logic [AW:0]                 outstanding,
    output logic                        protocol_error
);
    typedef struct packed {
        logic [SW-1:0]   sub;
        logic [2:0]      fn3;
        logic [1:0]      off;
        logic [ID_W-1:0] id;
    } entry_t;

    entry_t                   mem_q [MAX_INFLIGHT];
    entry_t                   head;
    logic [AW:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic                     empty, full, push, accept, stray;
    logic [NUM_SUB_UNITS-1:0] match;
    logic [31:0]              raw, aligned;
    logic [15:0]              sh;
    logic                     wb_valid_q, wb_valid_d, err_q, err_d;
    logic [ID_W-1:0]          wb_id_q, wb_id_d;
    logic [31:0]              wb_data_q, wb_data_d;

    always_comb begin
        head    = mem_q[rptr_q[AW-1:0]];
        empty   = wptr_q == rptr_q;
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        push    = issue_valid && !full;
        match   = NUM_SUB_UNITS'(1) << head.sub;
        accept  = !empty && |(sub_data_valid & match);
        // A strobe from any sub-unit other than the head's, or any strobe while empty, breaks ordering.
        stray   = empty ? |sub_data_valid : |(sub_data_valid & ~match);
        raw     = '0;
        for (int i = 0; i < NUM_SUB_UNITS; i++)
            if (head.sub == SW'(i)) raw = sub_data_out[32*i +: 32];
        sh      = 16'(raw >> {head.off, 3'b000});
        aligned = (head.fn3[1:0] == 2'b00) ? {{24{~head.fn3[2] & sh[7]}}, sh[7:0]} :
                  (head.fn3[1:0] == 2'b01) ? {{16{~head.fn3[2] & sh[15]}}, sh} : raw;
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = accept ? rptr_q + 1'b1 : rptr_q;
        wb_valid_d = accept;
        wb_id_d    = accept ? head.id : wb_id_q;
        wb_data_d  = accept ? aligned : wb_data_q;
        err_d      = err_q | stray;
    end

    always_ff @(posedge clk)
        if (push) mem_q[wptr_q[AW-1:0]] <= '{issue_sub_id, issue_fn3, issue_offset, issue_id};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_id_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            wb_valid_q <= wb_valid_d;
            wb_id_q    <= wb_id_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign issue_ready    = !full;
    assign outstanding    = wptr_q - rptr_q;
    assign wb_valid       = wb_valid_q;
    assign wb_id          = wb_id_q;
    assign wb_data        = wb_data_q;
    assign protocol_error = err_q;
endmodule

// File: tb/tb_load_response_align.sv
// tb_load_response_align: directed checks of alignment, FIFO fill/drop, wrap, ordering errors and async reset.
module tb_load_response_align;
    logic        clk = 1'b0, rst = 1'b1;
    logic        issue_valid = 1'b0, issue_ready;
    logic [0:0]  issue_sub_id = '0;
    logic [2:0]  issue_fn3 = '0;
    logic [1:0]  issue_offset = '0;
    logic [2:0]  issue_id = '0;
    logic [1:0]  sub_data_valid = '0;
    logic [63:0] sub_data_out = '0;
    logic        wb_valid, protocol_error;
    logic [2:0]  wb_id, outstanding;
    logic [31:0] wb_data;
    int          checks = 0, failures = 0;

    load_response_align #(.NUM_SUB_UNITS(2), .MAX_INFLIGHT(4), .ID_W(3)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_sub_id(issue_sub_id), .issue_fn3(issue_fn3), .issue_offset(issue_offset),
        .issue_id(issue_id), .sub_data_valid(sub_data_valid), .sub_data_out(sub_data_out),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .outstanding(outstanding),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs and returns at the following negedge, after the posedge took effect.
    task automatic tick(input logic iv, input logic isub, input logic [2:0] fn, input logic [1:0] off,
                        input logic [2:0] id, input logic [1:0] dv, input logic [31:0] d0, input logic [31:0] d1);
        issue_valid = iv; issue_sub_id = isub; issue_fn3 = fn; issue_offset = off; issue_id = id;
        sub_data_valid = dv; sub_data_out = {d1, d0};
        @(negedge clk);
        issue_valid = 1'b0; sub_data_valid = '0;
    endtask

    task automatic load(input logic isub, input logic [2:0] fn, input logic [1:0] off, input logic [2:0] id,
                        input logic [31:0] d, input logic [31:0] exp, input string tag);
        tick(1, isub, fn, off, id, 2'b00, 0, 0);
        check({tag, "_outst"}, outstanding, 1);
        tick(0, 0, 0, 0, 0, isub ? 2'b10 : 2'b01, isub ? 32'h0 : d, isub ? d : 32'h0);
        check({tag, "_wbv"}, wb_valid, 1);
        check({tag, "_wbid"}, wb_id, id);
        check({tag, "_data"}, wb_data, exp);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_wbid", wb_id, 0);
        check("rst_wbdata", wb_data, 0);
        check("rst_outst", outstanding, 0);
        check("rst_err", protocol_error, 0);
        check("rst_ready", issue_ready, 1);

        load(0, 3'b000, 2'd2, 3'd5, 32'h1180_3344, 32'hFFFF_FF80, "lb");
        tick(0, 0, 0, 0, 0, 0, 0, 0);
        check("wbv_one_cycle", wb_valid, 0);
        load(0, 3'b100, 2'd2, 3'd6, 32'h1180_3344, 32'h0000_0080, "lbu");
        load(1, 3'b001, 2'd2, 3'd1, 32'h9ABC_1234, 32'hFFFF_9ABC, "lh");
        load(1, 3'b101, 2'd2, 3'd2, 32'h9ABC_1234, 32'h0000_9ABC, "lhu");
        load(0, 3'b010, 2'd1, 3'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "lw");
        load(1, 3'b001, 2'd3, 3'd4, 32'h9ABC_1234, 32'h0000_009A, "lh_mis");
        load(0, 3'b000, 2'd3, 3'd7, 32'h8000_0000, 32'hFFFF_FF80, "lb_off3");
        load(1, 3'b011, 2'd2, 3'd0, 32'h1234_5678, 32'h1234_5678, "fn011");
        check("no_err_yet", protocol_error, 0);

        for (int k = 0; k < 4; k++) tick(1, k[0], 3'b010, 0, 3'(k), 0, 0, 0);
        check("full_ready", issue_ready, 0);
        check("full_outst", outstanding, 4);
        tick(1, 0, 3'b010, 0, 3'd4, 2'b01, 32'hAA, 0);
        check("drop_outst", outstanding, 3);
        check("drop_wbv", wb_valid, 1);
        check("drop_wbid", wb_id, 0);
        check("drop_ready", issue_ready, 1);
        for (int k = 1; k < 4; k++) begin
            tick(0, 0, 0, 0, 0, k[0] ? 2'b10 : 2'b01, 32'h10 + k, 32'h10 + k);
            check("drain_wbid", wb_id, k);
            check("drain_data", wb_data, 32'h10 + k);
        end
        check("drain_outst", outstanding, 0);

        tick(1, 0, 3'b010, 0, 3'd0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            tick(1, k[0], 3'b010, 0, 3'(k), (k - 1) % 2 == 1 ? 2'b10 : 2'b01, 32'h100 + k - 1, 32'h100 + k - 1);
            check("b2b_wbv", wb_valid, 1);
            check("b2b_wbid", wb_id, k - 1);
            check("b2b_data", wb_data, 32'h100 + k - 1);
            check("b2b_outst", outstanding, 1);
        end
        tick(0, 0, 0, 0, 0, 2'b01, 32'h106, 0);
        check("b2b_last_wbid", wb_id, 6);
        check("b2b_last_outst", outstanding, 0);

        tick(1, 1, 3'b010, 0, 3'd1, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 2'b01, 32'h55, 0);
        check("wrong_sub_err", protocol_error, 1);
        check("wrong_sub_wbv", wb_valid, 0);
        check("wrong_sub_outst", outstanding, 1);
        tick(0, 0, 0, 0, 0, 2'b10, 0, 32'h77);
        check("after_err_wbv", wb_valid, 1);
        check("after_err_wbid", wb_id, 1);
        check("err_sticky", protocol_error, 1);
        tick(0, 0, 0, 0, 0, 2'b10, 0, 32'h99);
        check("empty_err", protocol_error, 1);
        check("empty_wbv", wb_valid, 0);
        check("empty_outst", outstanding, 0);

        for (int k = 0; k < 4; k++) tick(1, 0, 3'b010, 0, 3'(k + 2), 0, 0, 0);
        tick(0, 0, 0, 0, 0, 2'b01, 32'hCAFE_F00D, 0);
        check("pre_rst_wbv", wb_valid, 1);
        check("pre_rst_outst", outstanding, 3);
        #2 rst = 1'b1;
        #1;
        check("async_wbv", wb_valid, 0);
        check("async_wbid", wb_id, 0);
        check("async_wbdata", wb_data, 0);
        check("async_outst", outstanding, 0);
        check("async_err", protocol_error, 0);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_ready", issue_ready, 1);
        tick(0, 0, 0, 0, 0, 2'b01, 32'h1, 0);
        check("post_rst_resp_err", protocol_error, 1);
        check("post_rst_resp_wbv", wb_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_response_align.md
Name: load_response_align

Overview:
- Sits between the load/store unit's sub-unit dispatch and the memory sub-units, including local memory, bus and cache.
- Records every issued load in an in-order tracking FIFO and collects each sub-unit's raw 32-bit word when that sub-unit pulses data_valid.
- Extracts and sign- or zero-extends the addressed byte, halfword or word.
- Presents the result, one cycle later, as a registered writeback tagged with the load's instruction id.

Parameters:
- NUM_SUB_UNITS, 2, number of memory sub-units feeding responses (>=1).
- MAX_INFLIGHT, 4, tracking FIFO depth (power of two, >=2).
- ID_W, 3, width of the instruction id carried with each load.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- issue_valid  in  1  load issued to a sub-unit this cycle (store/SC-free loads only; stores never enter)
- issue_ready  out  1  FIFO can accept a load; = ~full
- issue_sub_id  in  $clog2(NUM_SUB_UNITS) (min 1)  sub-unit the load was sent to
- issue_fn3  in  3  RISC-V load funct3
- issue_offset  in  2  addr[1:0] of the load
- issue_id  in  ID_W  instruction id
- sub_data_valid  in  NUM_SUB_UNITS  per-sub-unit one-cycle response strobe
- sub_data_out  in  32*NUM_SUB_UNITS  per-sub-unit raw word; sub-unit i at bits [32i+31:32i]
- wb_valid  out  1  registered writeback strobe
- wb_id  out  ID_W  id of the retiring load
- wb_data  out  32  aligned, extended load data
- outstanding  out  $clog2(MAX_INFLIGHT)+1  loads in the FIFO
- protocol_error  out  1  sticky error flag

Behaviour:
- Reset: async, active-high. FIFO empty, outstanding=0, wb_valid=0, wb_id=0, wb_data=0, protocol_error=0, issue_ready=1 once rst deasserts.
- Enqueue: issue_valid & issue_ready pushes {sub_id, fn3, offset, id}. issue_valid while ~issue_ready is ignored, and the push is not retried.
- Response acceptance: a response is accepted when FIFO non-empty and sub_data_valid[head.sub_id]=1.
- Accepted response:
  - Pop the head.
  - Next cycle: wb_valid=1, wb_id=head.id, wb_data=aligned word.
  - wb_valid is high for exactly one cycle per accepted response.
  - No backpressure: responses are always consumed.
- Alignment: shifted = raw >> (offset*8). Then:
  - fn3=000 LB: sign-extend shifted[7:0].
  - fn3=100 LBU: zero-extend shifted[7:0].
  - fn3=001 LH: sign-extend shifted[15:0].
  - fn3=101 LHU: zero-extend shifted[15:0].
  - fn3=010 LW: raw unchanged; offset is ignored.
  - Other fn3: treat as LW.
- Misaligned halfword (offset=3): use shifted[15:0] as computed, whose upper byte is 0. No trap; misalignment is handled upstream.
- Ordering: sub-units are required to respond in issue order. The following set protocol_error=1 (sticky until reset):
  - Any sub_data_valid bit other than head.sub_id.
  - Any sub_data_valid while empty.
  - The offending strobe is otherwise ignored. A simultaneous head match is still accepted.
- Simultaneous push and pop:
  - Both happen in the same cycle; outstanding is unchanged.
  - When full, issue_ready=0 that cycle even if a pop occurs, so no push.
  - When empty, a push in the same cycle as a response does not satisfy that response. It is an error because the FIFO was empty.
- Pointers: MAX_INFLIGHT-wide wrap-around with an extra bit for the full/empty distinction. outstanding = wptr - rptr.
- Reset mid-operation: all in-flight entries are discarded. Responses after reset are flagged as errors (empty FIFO).

Test Plan:
- LB, offset 2, raw 0x11_80_33_44 from sub-unit 0, id 5 -> one cycle after data_valid: wb_valid=1, wb_id=5, wb_data=0xFFFFFF80. With fn3=100 instead -> wb_data=0x00000080.
- LH, offset 2, raw 0x9ABC_1234 -> wb_data=0xFFFF9ABC. LHU -> 0x00009ABC. LW, offset 1, raw 0xDEADBEEF -> 0xDEADBEEF.
- Fill 4 loads (ids 0-3, alternating sub-units 0/1) without responses -> issue_ready=0, outstanding=4. Then issue id 4 with issue_valid=1 and a response in the same cycle -> id 4 dropped, outstanding=3, wb_id=0 next cycle.
- Back-to-back responses on 6 consecutive cycles with a continuous issue stream, crossing pointer wrap -> wb_id sequence matches issue order and wb_valid is high 6 consecutive cycles.
- Head expects sub-unit 1 but sub-unit 0 strobes; also a strobe while empty -> protocol_error=1 and stays 1, no wb_valid, outstanding unchanged.
- Assert rst asynchronously mid-cycle with 3 loads outstanding -> outputs clear immediately, outstanding=0, protocol_error=0, issue_ready=1 after release.
